// File: rtl/key_cmd_pkg.sv
// rtl/key_cmd_pkg.sv - command codes, key bit positions and arbitration helpers
package key_cmd_pkg;

   localparam logic [2:0] CMD_NONE   = 3'b000;
   localparam logic [2:0] CMD_DOWN   = 3'b100;
   localparam logic [2:0] CMD_LEFT   = 3'b101;
   localparam logic [2:0] CMD_RIGHT  = 3'b110;
   localparam logic [2:0] CMD_ROTATE = 3'b111;

   localparam int GRAVITY_TICKS_DEFAULT = 50_000_000;

   // Down sits in the MSB because it has the highest arbitration priority.
   localparam int K_DOWN  = 3;
   localparam int K_LEFT  = 2;
   localparam int K_RIGHT = 1;
   localparam int K_UP    = 0;

   typedef logic [3:0] key_set_t;

   function automatic key_set_t pick_highest(input key_set_t pend);
      key_set_t g;
      g = '0;
      if (pend[K_DOWN])       g[K_DOWN]  = 1'b1;
      else if (pend[K_LEFT])  g[K_LEFT]  = 1'b1;
      else if (pend[K_RIGHT]) g[K_RIGHT] = 1'b1;
      else if (pend[K_UP])    g[K_UP]    = 1'b1;
      return g;
   endfunction

   function automatic logic [2:0] grant_cmd(input key_set_t g);
      logic [2:0] c;
      c = CMD_NONE;
      if (g[K_DOWN])       c = CMD_DOWN;
      else if (g[K_LEFT])  c = CMD_LEFT;
      else if (g[K_RIGHT]) c = CMD_RIGHT;
      else if (g[K_UP])    c = CMD_ROTATE;
      return c;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - first-word-fall-through queue of 3-bit move commands
module cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       flush,
   input  logic       push,
   input  logic [2:0] push_data,
   input  logic       pop,
   output logic [2:0] head,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign head    = mem[rd_ptr];
   // A full queue still takes a write when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 3'b000;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/key_command_queue.sv
// rtl/key_command_queue.sv - key levels and gravity to queued one-shot move commands
// Define KEY_CMD_AUTO_REPEAT_EN for hold-to-repeat on left/right/down.
module key_command_queue
   import key_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int GRAVITY_TICKS = GRAVITY_TICKS_DEFAULT
`ifdef KEY_CMD_AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
`endif
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       left,
   input  logic       right,
   input  logic       down,
   input  logic       up,
   input  logic       space,
   input  logic       fail,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   output logic       game_rst,
   output logic [7:0] drop_cnt
);

   localparam int GW = $clog2(GRAVITY_TICKS);
   localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_TICKS - 1);

   key_set_t      key_cur, key_prev, key_rise, pend, events, merged, grant;
   logic          space_cur, space_prev, space_rise;
   logic          grav_tick, fifo_full, fifo_empty, fifo_pop, can_write;
   logic [GW-1:0] grav_cnt;
   logic [2:0]    head;

   assign space_rise = space_cur & ~space_prev;
   assign key_rise   = key_cur & ~key_prev;
   assign grav_tick  = ~fail & (grav_cnt == GRAV_LAST);

`ifdef KEY_CMD_AUTO_REPEAT_EN
   localparam logic [31:0] REP_FIRST = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] REP_LAST  = 32'(REPEAT_DELAY + REPEAT_PERIOD - 1);

   logic [31:0] hold_cnt [K_RIGHT:K_DOWN];
   key_set_t    rep;

   always_comb begin
      rep = '0;
      for (int i = K_RIGHT; i <= K_DOWN; i++)
         rep[i] = key_cur[i] & ((hold_cnt[i] == REP_FIRST) | (hold_cnt[i] == REP_LAST));
   end

   // After the first repeat the counter cycles over the repeat period only.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = K_RIGHT; i <= K_DOWN; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = K_RIGHT; i <= K_DOWN; i++) begin
            if (!key_cur[i] || space_rise || fail) hold_cnt[i] <= '0;
            else if (hold_cnt[i] == REP_LAST)    hold_cnt[i] <= 32'(REPEAT_DELAY);
            else                                 hold_cnt[i] <= hold_cnt[i] + 32'd1;
         end
      end
   end

   always_comb begin
      events         = fail ? '0 : (key_rise | rep);
      events[K_DOWN] = events[K_DOWN] | grav_tick;
   end
`else
   always_comb begin
      events         = fail ? '0 : key_rise;
      events[K_DOWN] = events[K_DOWN] | grav_tick;
   end
`endif

   assign fifo_pop  = ~fifo_empty & cmd_ready;
   assign can_write = (~fifo_full | fifo_pop) & ~space_rise;
   assign grant     = can_write ? pick_highest(pend) : '0;
   assign merged    = events & pend;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         key_cur    <= '0;
         key_prev   <= '0;
         space_cur  <= 1'b0;
         space_prev <= 1'b0;
         pend       <= '0;
         grav_cnt   <= '0;
         game_rst   <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         key_cur    <= {down, left, right, up};
         key_prev   <= key_cur;
         space_cur  <= space;
         space_prev <= space_cur;
         game_rst   <= space_rise;
         // A space press wipes the queue state and swallows same-cycle events.
         if (space_rise) begin
            pend     <= '0;
            grav_cnt <= '0;
         end else begin
            pend <= (pend | events) & ~grant;
            if (!fail) grav_cnt <= (grav_cnt == GRAV_LAST) ? '0 : grav_cnt + GW'(1);
            if ((|merged) && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   cmd_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .clrn      (clrn),
      .flush     (space_rise),
      .push      (|grant),
      .push_data (grant_cmd(grant)),
      .pop       (fifo_pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cmd_valid = ~fifo_empty;
   assign cmd       = cmd_valid ? head : CMD_NONE;

endmodule
